ss_square_accum: RTL and testbench
==================================

Name: ss_square_accum

Overview:
Downstream consumer of the start-detect stage's write-start pulse (i_w_start).
- Per pulse, accepts i_len signed samples over a valid/ready stream and accumulates the sum of their squares.
- Presents the result and a one-cycle o_done pulse; o_done feeds the start-detect stage's i_done.
- Single clock domain; sequencing is a small FSM with a 2-stage square/accumulate pipeline.

Parameters:
DATA_W, 16, signed sample width
LEN_W, 8, length field width (max 2^LEN_W-1 samples per job)
ACC_W, 40, accumulator/result width (unsigned), must be >= 2*DATA_W

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_w_start  in  1  one-cycle job start pulse
i_len  in  LEN_W  sample count, sampled on the i_w_start cycle
i_data_valid  in  1  sample valid
i_data  in  DATA_W  signed sample
o_data_ready  out  1  block accepts a sample this cycle
o_busy  out  1  job in progress (state != IDLE)
o_result  out  ACC_W  sum of squares; held until the next accepted start
o_result_valid  out  1  high while o_result is from a completed job
o_done  out  1  one-cycle completion pulse
o_ovf  out  1  accumulator overflow seen in the current or last job

Behaviour:
- Reset (async assert, released synchronously to i_clk):
  - All outputs 0; state IDLE; count, accumulator and pipeline valid bits cleared.
  - Reset mid-job aborts the job with no o_done.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - i_w_start=1 with i_len!=0 -> RUN. Latch i_len; clear accumulator, count, o_ovf and o_result_valid.
  - i_w_start=1 with i_len==0 -> DONE. o_result=0, o_ovf=0.
- RUN:
  - o_data_ready=1 combinationally.
  - A beat is accepted when i_data_valid & o_data_ready.
  - Stage 1 registers the square i_data*i_data (unsigned, 2*DATA_W bits) plus a valid bit.
  - Stage 2 adds the zero-extended square to the accumulator on the next edge.
  - count increments per accepted beat. Accepting the beat where count==len-1 -> FLUSH; o_data_ready drops in the following cycle.
  - Valid gaps stall the count and do not affect the result.
- FLUSH: one cycle while stage 1 drains into the accumulator -> DONE.
- DONE:
  - o_done=1 and o_result_valid=1; o_result = accumulator.
  - -> IDLE on the next edge.
  - o_result and o_result_valid hold in IDLE until the next accepted i_w_start.
- Latency: o_done is high in the 2nd cycle after the edge that accepts the last beat. For len=0, o_done is high in the cycle after the start edge.
- i_w_start while o_busy=1 is ignored (no relatch, no restart).
- i_w_start in the same cycle as o_done (state DONE) is ignored.
- o_data_ready=0 in IDLE, FLUSH and DONE. Samples presented then are not consumed.
- Most negative input: (-2^(DATA_W-1))^2 = 2^(2*DATA_W-2), exact.

Optional Feature:
Macro SS_ACC_SAT_EN.
- Defined: an add carrying out of ACC_W bits saturates the accumulator at 2^ACC_W-1, holds it there, and sets o_ovf (sticky until the next accepted start).
- Undefined: the accumulator wraps modulo 2^ACC_W and o_ovf is tied 0.

Decomposition:
- Package ss_pkg: state enum ss_acc_state_t (IDLE/RUN/FLUSH/DONE) and the default width constants SS_DATA_W, SS_LEN_W, SS_ACC_W.
- Sub-module ss_square_stage: registered squarer with valid in/out, async active-high reset.
- FSM, counter and accumulator remain in the top module.

Test Plan:
- Basic: start, len=3, data 2,-3,4 back-to-back -> o_result=29, o_done one cycle exactly 2 cycles after the 3rd accepted beat, o_result_valid stays 1 afterwards.
- Zero length: start, len=0 -> o_done next cycle, o_result=0, o_data_ready never 1.
- Backpressure gaps: len=4, data 1,1,1,1 with valid low 2 cycles between beats -> o_result=4, exactly 4 beats consumed; samples presented during FLUSH/DONE are not consumed.
- Start while busy: second i_w_start with len=9 during RUN of a len=2 job (data 5,5) -> o_result=50, one o_done only, i_len not relatched.
- Overflow, ACC_W=32, len=4, data -32768 x4: with SS_ACC_SAT_EN -> o_result=0xFFFFFFFF, o_ovf=1; without it -> o_result=0, o_ovf=0.
- Reset mid-job: assert i_rst after 2 of 5 beats -> all outputs 0 immediately, no o_done. A new start, len=1, data 7 -> o_result=49.

Source files
------------

// File: rtl/ss_pkg.sv
// Shared definitions for the sum-of-squares accumulator: FSM state encoding
// and default widths.
package ss_pkg;

  localparam int SS_DATA_W = 16;
  localparam int SS_LEN_W  = 8;
  localparam int SS_ACC_W  = 40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } ss_acc_state_t;

endpackage

// File: rtl/ss_square_stage.sv
// Registered squarer: one pipeline stage producing the unsigned square of a
// signed sample together with its valid bit.
module ss_square_stage #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [DATA_W-1:0]     sample,
  output logic                  sq_valid,
  output logic [2*DATA_W-1:0]   square
);

  // A signed square is never negative and the largest magnitude,
  // (-2^(DATA_W-1))^2 = 2^(2*DATA_W-2), still fits in 2*DATA_W bits.
  logic signed [2*DATA_W-1:0] prod;

  assign prod = $signed(sample) * $signed(sample);

  // Register the square and its valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_valid <= 1'b0;
      square   <= '0;
    end else begin
      sq_valid <= valid;
      square   <= $unsigned(prod);
    end
  end

endmodule

// File: rtl/ss_square_accum.sv
// Sum-of-squares accumulator. One job per i_w_start pulse: accept i_len
// signed samples over valid/ready, accumulate their squares, then pulse
// o_done with the result.
// Optional build macro SS_ACC_SAT_EN: saturate the accumulator at
// 2^ACC_W-1 and flag o_ovf; without it the accumulator wraps and o_ovf is 0.
//
// state | meaning
// IDLE  | waiting for i_w_start; previous result held
// RUN   | accepting samples until len beats are taken
// FLUSH | last square drains from the squarer into the accumulator
// DONE  | o_done pulse, result valid
module ss_square_accum
  import ss_pkg::*;
#(
  parameter int DATA_W = SS_DATA_W,
  parameter int LEN_W  = SS_LEN_W,
  parameter int ACC_W  = SS_ACC_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_w_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_data_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_data_ready,
  output logic              o_busy,
  output logic [ACC_W-1:0]  o_result,
  output logic              o_result_valid,
  output logic              o_done,
  output logic              o_ovf
);

  ss_acc_state_t       state;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    count;
  logic [ACC_W-1:0]    acc;
  logic                accept;
  logic                last_beat;
  logic                sq_valid;
  logic [2*DATA_W-1:0] square;
  logic [ACC_W-1:0]    sq_ext;
  logic                result_valid;
  logic                done;

  assign o_data_ready = (state == RUN);
  assign accept       = i_data_valid & o_data_ready;
  assign last_beat    = (count == len_q - LEN_W'(1));
  assign sq_ext       = ACC_W'(square);

  assign o_busy         = (state != IDLE);
  assign o_result       = acc;
  assign o_result_valid = result_valid;
  assign o_done         = done;

  ss_square_stage #(
    .DATA_W (DATA_W)
  ) u_square (
    .clk      (i_clk),
    .rst      (i_rst),
    .valid    (accept),
    .sample   (i_data),
    .sq_valid (sq_valid),
    .square   (square)
  );

`ifdef SS_ACC_SAT_EN
  logic [ACC_W:0] sum;
  logic           ovf;

  assign sum   = {1'b0, acc} + {1'b0, sq_ext};
  assign o_ovf = ovf;
`else
  assign o_ovf = 1'b0;
`endif

  // Sequencing FSM with the beat counter and accumulator. The accumulator
  // doubles as the result register: it is only cleared by an accepted start.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      len_q        <= '0;
      count        <= '0;
      acc          <= '0;
      result_valid <= 1'b0;
      done         <= 1'b0;
`ifdef SS_ACC_SAT_EN
      ovf          <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      if (sq_valid) begin
`ifdef SS_ACC_SAT_EN
        if (sum[ACC_W]) begin
          acc <= '1;
          ovf <= 1'b1;
        end else begin
          acc <= sum[ACC_W-1:0];
        end
`else
        acc <= acc + sq_ext;
`endif
      end

      case (state)
        IDLE: begin
          if (i_w_start) begin
            acc          <= '0;
            count        <= '0;
            result_valid <= 1'b0;
`ifdef SS_ACC_SAT_EN
            ovf          <= 1'b0;
`endif
            if (i_len != '0) begin
              len_q <= i_len;
              state <= RUN;
            end else begin
              state        <= DONE;
              done         <= 1'b1;
              result_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            count <= count + LEN_W'(1);
            if (last_beat) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          state        <= DONE;
          done         <= 1'b1;
          result_valid <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ss_square_accum.sv
// Self-checking bench for ss_square_accum (ACC_W=32 so overflow is reachable).
// Expected job results are queued when a job is started and compared when
// the DUT pulses o_done.
module tb_ss_square_accum;

  localparam int DATA_W = 16;
  localparam int LEN_W  = 8;
  localparam int ACC_W  = 32;

  logic              clk;
  logic              rst;
  logic              w_start;
  logic [LEN_W-1:0]  len;
  logic              data_valid;
  logic [DATA_W-1:0] data;
  logic              data_ready;
  logic              busy;
  logic [ACC_W-1:0]  result;
  logic              result_valid;
  logic              done;
  logic              ovf;

  typedef struct {
    logic [ACC_W-1:0] res;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int accepted = 0;
  int dones    = 0;

  ss_square_accum #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .ACC_W  (ACC_W)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_w_start      (w_start),
    .i_len          (len),
    .i_data_valid   (data_valid),
    .i_data         (data),
    .o_data_ready   (data_ready),
    .o_busy         (busy),
    .o_result       (result),
    .o_result_valid (result_valid),
    .o_done         (done),
    .o_ovf          (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor away from the active edge: count consumed beats and score results.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid && data_ready) accepted++;
      if (done) begin
        dones++;
        if (exp_q.size() == 0) begin
          check_val("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_val("sb_result", result, e.res);
          check_val("sb_ovf", ovf, e.ovf);
          check_val("sb_result_valid", result_valid, 1);
        end
      end
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_job(input logic [LEN_W-1:0] l, input logic [ACC_W-1:0] r, input logic o);
    exp_t e;
    e.res = r;
    e.ovf = o;
    exp_q.push_back(e);
    w_start = 1'b1;
    len     = l;
    @(posedge clk);
    #1;
    w_start = 1'b0;
    len     = '0;
  endtask

  // Present one sample and hold it until accepted; returns 1 cycle after the
  // accepting edge.
  task automatic send_beat(input logic [DATA_W-1:0] d);
    bit ok;
    ok = 1'b0;
    data_valid = 1'b1;
    data       = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (data_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("beat_accept_timeout", ok, 1);
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  // After the accepting edge of the last beat: o_done low, then high, then low.
  task automatic check_done_latency(input string tag);
    @(negedge clk);
    check_val({tag, "_done_early"}, done, 0);
    @(negedge clk);
    check_val({tag, "_done_pulse"}, done, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val({tag, "_done_width"}, done, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_result"}, result, 0);
    check_val({tag, "_result_valid"}, result_valid, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_ready"}, data_ready, 0);
    check_val({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc0;
    int dn0;
    logic [ACC_W-1:0] ovf_res;
    logic             ovf_flag;

    rst        = 1'b1;
    w_start    = 1'b0;
    len        = '0;
    data_valid = 1'b0;
    data       = '0;
    cycles(3);
    check_idle_outputs("reset");
    rst = 1'b0;
    cycles(2);

    // Basic: 4 + 9 + 16 = 29, back-to-back beats.
    start_job(8'd3, 32'd29, 1'b0);
    check_val("basic_busy", busy, 1);
    check_val("basic_rv_cleared", result_valid, 0);
    send_beat(16'd2);
    send_beat(-16'sd3);
    send_beat(16'd4);
    check_done_latency("basic");
    cycles(5);
    check_val("basic_rv_hold", result_valid, 1);
    check_val("basic_result_hold", result, 29);
    check_val("basic_idle", busy, 0);

    // Zero length: done in the cycle after the start edge, never ready.
    start_job(8'd0, 32'd0, 1'b0);
    @(negedge clk);
    check_val("zero_done", done, 1);
    check_val("zero_ready", data_ready, 0);
    cycles(1);
    @(negedge clk);
    check_val("zero_done_width", done, 0);
    check_val("zero_ready_after", data_ready, 0);
    cycles(2);

    // Valid gaps, then samples presented while the block is not ready.
    acc0 = accepted;
    start_job(8'd4, 32'd4, 1'b0);
    for (int b = 0; b < 4; b++) begin
      send_beat(16'd1);
      if (b < 3) cycles(2);
    end
    data_valid = 1'b1;
    data       = 16'd100;
    check_done_latency("gaps");
    cycles(2);
    data_valid = 1'b0;
    check_val("gaps_beats", accepted - acc0, 4);
    check_val("gaps_result_hold", result, 4);

    // Second start during RUN is ignored.
    dn0 = dones;
    start_job(8'd2, 32'd50, 1'b0);
    send_beat(16'd5);
    w_start = 1'b1;
    len     = 8'd9;
    cycles(1);
    w_start = 1'b0;
    len     = '0;
    send_beat(16'd5);
    check_done_latency("busy_start");
    cycles(20);
    check_val("busy_start_dones", dones - dn0, 1);
    check_val("busy_start_idle", busy, 0);
    check_val("busy_start_ready", data_ready, 0);

    // Overflow: 4 * 2^30 = 2^32.
`ifdef SS_ACC_SAT_EN
    ovf_res  = 32'hFFFF_FFFF;
    ovf_flag = 1'b1;
`else
    ovf_res  = 32'h0;
    ovf_flag = 1'b0;
`endif
    start_job(8'd4, ovf_res, ovf_flag);
    for (int b = 0; b < 4; b++) send_beat(16'h8000);
    check_done_latency("ovf");
    cycles(3);
    check_val("ovf_hold", ovf, ovf_flag);

    // Reset mid-job aborts with no done.
    dn0 = dones;
    start_job(8'd5, 32'd0, 1'b0);
    send_beat(16'd3);
    send_beat(16'd3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    exp_q.delete();
    cycles(2);
    rst = 1'b0;
    cycles(10);
    check_val("midrst_no_done", dones - dn0, 0);

    start_job(8'd1, 32'd49, 1'b0);
    send_beat(16'd7);
    check_done_latency("after_rst");
    cycles(3);
    check_val("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
